// File: rtl/lsb_stego_embed.sv
// lsb_stego_embed
// Writes a message into the LSBs of a raw image channel stream. Each frame
// carries a 16-bit length header (MSB first), then the payload bytes (each
// MSB first, in arrival order). The rest of the frame passes through
// unchanged. If the message does not fit, cap_err is set and the whole
// frame passes through untouched.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, msg_len              frame start pulse and payload length in bytes
//   msg_data/valid/ready        payload byte stream
//   pix_in/valid/ready          raw channel stream (8 bits per transfer)
//   pix_out/valid/ready/last    stego channel stream, single output register
//   busy, done, cap_err         frame status
module lsb_stego_embed #(
  parameter int NUM_CHANNELS = 196608,
  parameter int CNT_W        = $clog2(NUM_CHANNELS + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] msg_len,
  input  logic [7:0]  msg_data,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  pix_in,
  input  logic        pix_in_valid,
  output logic        pix_in_ready,
  output logic [7:0]  pix_out,
  output logic        pix_out_valid,
  input  logic        pix_out_ready,
  output logic        pix_out_last,
  output logic        busy,
  output logic        done,
  output logic        cap_err
);

  // Wide enough for 16 + 8*65535 and for NUM_CHANNELS, so the capacity
  // check cannot overflow.
  localparam int END_W = (CNT_W + 4 > 20) ? CNT_W + 4 : 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PASS,
    S_DONE
  } state_t;

  state_t           state;
  logic [15:0]      len_q;
  logic [15:0]      bytes_loaded;
  logic [CNT_W-1:0] ch_cnt;
  logic [END_W-1:0] end_q;       // channel index one past the last payload bit
  logic [7:0]       shreg;       // current payload byte, next bit in [7]
  logic [2:0]       bit_idx;
  logic             full;

  logic [END_W-1:0] need_bits;
  logic             fits;
  logic             in_frame;
  logic             in_fire;
  logic             msg_fire;
  logic             out_fire;
  logic             consume_last;
  logic             last_in;
  logic             payload_end;
  logic             embed_bit;
  logic [7:0]       pix_next;

  assign need_bits = END_W'(16) + END_W'({msg_len, 3'b000});
  assign fits      = need_bits <= END_W'(NUM_CHANNELS);

  // Once all NUM_CHANNELS inputs are taken the frame stops accepting input
  // while the final output drains.
  assign in_frame = (state == S_HEADER || state == S_PAYLOAD || state == S_PASS)
                    && (ch_cnt != CNT_W'(NUM_CHANNELS));

  assign pix_in_ready = in_frame && (!pix_out_valid || pix_out_ready)
                        && (state != S_PAYLOAD || full);
  assign in_fire      = pix_in_valid && pix_in_ready;
  assign out_fire     = pix_out_valid && pix_out_ready;

  // A new byte may load in the same cycle the last bit of the old one is
  // used, so the payload runs without bubbles.
  assign consume_last = in_fire && (state == S_PAYLOAD) && (bit_idx == 3'd7);
  assign msg_ready    = (state == S_PAYLOAD) && (bytes_loaded < len_q)
                        && (!full || consume_last);
  assign msg_fire     = msg_valid && msg_ready;

  assign last_in     = ch_cnt == CNT_W'(NUM_CHANNELS - 1);
  assign payload_end = (END_W'(ch_cnt) + END_W'(1)) == end_q;
  assign busy        = state != S_IDLE;

  // NOTE: every signal written in always_comb gets a default first so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    embed_bit = 1'b0;
    pix_next  = pix_in;
    if (state == S_HEADER) begin
      embed_bit = len_q[4'd15 - ch_cnt[3:0]];
      pix_next  = {pix_in[7:1], embed_bit};
    end else if (state == S_PAYLOAD) begin
      embed_bit = shreg[7];
      pix_next  = {pix_in[7:1], embed_bit};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the byte buffer is tiny, so it is reset along with the control
      // state; an aborted frame leaves nothing stale behind.
      state         <= S_IDLE;
      len_q         <= '0;
      bytes_loaded  <= '0;
      ch_cnt        <= '0;
      end_q         <= '0;
      shreg         <= '0;
      bit_idx       <= '0;
      full          <= 1'b0;
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      pix_out_last  <= 1'b0;
      done          <= 1'b0;
      cap_err       <= 1'b0;
    end else begin
      done <= 1'b0;

      // Output register: loads on input handshake, holds while stalled.
      if (in_fire) begin
        pix_out       <= pix_next;
        pix_out_valid <= 1'b1;
        pix_out_last  <= last_in;
        ch_cnt        <= ch_cnt + CNT_W'(1);
      end else if (pix_out_ready) begin
        pix_out_valid <= 1'b0;
      end

      // Message buffer.
      if (msg_fire) begin
        shreg        <= msg_data;
        bit_idx      <= 3'd0;
        full         <= 1'b1;
        bytes_loaded <= bytes_loaded + 16'd1;
      end else if (in_fire && state == S_PAYLOAD) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_idx <= bit_idx + 3'd1;
        if (bit_idx == 3'd7) full <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q        <= msg_len;
            end_q        <= need_bits;
            ch_cnt       <= '0;
            bytes_loaded <= '0;
            bit_idx      <= 3'd0;
            full         <= 1'b0;
            cap_err      <= !fits;
            state        <= fits ? S_HEADER : S_PASS;
          end
        end
        S_HEADER, S_PAYLOAD, S_PASS: begin
          if (out_fire && pix_out_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (state == S_HEADER && in_fire && ch_cnt == CNT_W'(15)) begin
            state <= (len_q == 16'd0) ? S_PASS : S_PAYLOAD;
          end else if (state == S_PAYLOAD && in_fire && payload_end) begin
            state <= S_PASS;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_stego_embed.sv
module tb_lsb_stego_embed;
  localparam int NCH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] msg_len;
  logic [7:0]  msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  pix_in;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic [7:0]  pix_out;
  logic        pix_out_valid;
  logic        pix_out_ready;
  logic        pix_out_last;
  logic        busy;
  logic        done;
  logic        cap_err;

  always #5 clk = ~clk;

  lsb_stego_embed #(.NUM_CHANNELS(NCH)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
    .pix_out_last(pix_out_last), .busy(busy), .done(done), .cap_err(cap_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  logic [7:0] pix_vals [NCH];
  logic [7:0] msg_bytes[8];
  logic [7:0] exp_out  [NCH];
  logic [7:0] got      [NCH];
  bit         exp_cap;
  int         last_cycles;

  // Reference model: the list of bits to hide, laid over channel LSBs.
  function automatic void build_model(input int len);
    bit         bits[$];
    logic [15:0] l;
    l       = len[15:0];
    exp_cap = (16 + 8 * len) > NCH;
    if (!exp_cap) begin
      for (int i = 15; i >= 0; i--) bits.push_back(l[i]);
      for (int b = 0; b < len; b++)
        for (int k = 7; k >= 0; k--) bits.push_back(msg_bytes[b][k]);
    end
    for (int ch = 0; ch < NCH; ch++)
      exp_out[ch] = (ch < bits.size()) ? {pix_vals[ch][7:1], bits[ch]} : pix_vals[ch];
  endfunction

  function automatic logic [7:0] nominal_lit(input int ch);
    logic [7:0] p0;
    logic [7:0] p1;
    p0 = 8'hA5;
    p1 = 8'h3C;
    if (ch < 16) return (ch == 14) ? 8'hFF : 8'hFE;
    if (ch < 24) return {7'h7F, p0[23 - ch]};
    if (ch < 32) return {7'h7F, p1[31 - ch]};
    return 8'hFF;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_msg_ready"},     msg_ready,     0);
    check({tag, "_pix_in_ready"},  pix_in_ready,  0);
    check({tag, "_pix_out"},       pix_out,       0);
    check({tag, "_pix_out_valid"}, pix_out_valid, 0);
    check({tag, "_pix_out_last"},  pix_out_last,  0);
    check({tag, "_busy"},          busy,          0);
    check({tag, "_done"},          done,          0);
    check({tag, "_cap_err"},       cap_err,       0);
  endtask

  // Runs one frame; the loop below is the per-cycle compare process.
  task automatic run_frame(input int len, input bit bp, input bit gaps,
                           input int inj_at, input int abort_after);
    int         pi = 0, mi = 0, oi = 0, cyc = 0;
    bit         done_due = 0, stalled = 0, injected = 0, finished = 0, aborted = 0;
    bit         next_due;
    logic [7:0] stall_val = 8'h00;
    build_model(len);
    for (int i = 0; i < NCH; i++) got[i] = 8'hxx;
    @(negedge clk);
    start = 1'b1; msg_len = len[15:0];
    pix_in_valid = 1'b0; msg_valid = 1'b0; pix_out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; msg_len = 16'($urandom);
    #4;
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", pix_in_ready, 1);
    check("cap_err_on_start", cap_err, exp_cap);
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inj_at >= 0 && !injected && pi == inj_at) begin
        start = 1'b1; msg_len = 16'd5; injected = 1;
      end
      if (pi < NCH) begin
        pix_in_valid = !bp || ($urandom_range(0, 3) != 0);
        pix_in       = pix_vals[pi];
      end else begin
        pix_in_valid = 1'b1;
        pix_in       = 8'($urandom);
      end
      msg_valid     = (mi < 8) && (!gaps || $urandom_range(0, 1) == 1);
      msg_data      = (mi < 8) ? msg_bytes[mi] : 8'h00;
      pix_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (stalled) begin
        check("stall_valid", pix_out_valid, 1);
        check("stall_hold", pix_out, stall_val);
      end
      check("done_timing", done, done_due);
      if (done_due) finished = 1;
      if (exp_cap) check("msg_ready_cap", msg_ready, 0);
      if (pi >= NCH) check("no_extra_input", pix_in_ready, 0);
      if (pix_in_valid && pix_in_ready) pi++;
      if (msg_valid && msg_ready) mi++;
      next_due = 0;
      if (pix_out_valid && pix_out_ready) begin
        if (oi < NCH) begin
          check("pix_out", pix_out, exp_out[oi]);
          check("pix_out_last", pix_out_last, oi == NCH - 1);
          got[oi] = pix_out;
        end else begin
          check("extra_output_index", oi, NCH - 1);
        end
        next_due = pix_out_last;
        oi++;
      end
      done_due = next_due;
      stalled   = pix_out_valid && !pix_out_ready;
      stall_val = pix_out;
      if (abort_after > 0 && cyc >= abort_after) begin
        finished = 1; aborted = 1;
      end
    end
    last_cycles = cyc;
    if (!aborted) begin
      check("frame_completed", finished, 1);
      check("out_count", oi, NCH);
      check("bytes_taken", mi, exp_cap ? 0 : len);
      check("cap_err_end", cap_err, exp_cap);
      @(negedge clk);
      pix_in_valid = 1'b0; msg_valid = 1'b0;
      #4;
      check("idle_busy", busy, 0);
      check("idle_in_ready", pix_in_ready, 0);
      check("idle_done", done, 0);
    end
    pix_in_valid = 1'b0; msg_valid = 1'b0;
  endtask

  task automatic set_nominal();
    for (int i = 0; i < NCH; i++) pix_vals[i] = 8'hFF;
    msg_bytes[0] = 8'hA5; msg_bytes[1] = 8'h3C;
    for (int i = 2; i < 8; i++) msg_bytes[i] = 8'($urandom);
  endtask

  task automatic set_random();
    for (int i = 0; i < NCH; i++) pix_vals[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) msg_bytes[i] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; msg_len = 16'd0; msg_data = 8'd0; msg_valid = 1'b0;
    pix_in = 8'd0; pix_in_valid = 1'b0; pix_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #4 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #4 check_all_zero("post_reset");

    // Nominal frame with full throughput.
    set_nominal();
    run_frame(2, 0, 0, -1, 0);
    check("nominal_cycles", last_cycles, 67);
    for (int ch = 0; ch < NCH; ch++) check("nominal_lit", got[ch], nominal_lit(ch));

    // Backpressure and message gaps.
    set_nominal();
    run_frame(2, 1, 1, -1, 0);
    for (int ch = 0; ch < NCH; ch++) check("bp_lit", got[ch], nominal_lit(ch));

    // Exact capacity.
    set_random();
    run_frame(6, 1, 1, -1, 0);

    // Over capacity: pass-through, cap_err sticky.
    set_random();
    run_frame(7, 0, 0, -1, 0);
    for (int ch = 0; ch < NCH; ch++) check("cap_passthru", got[ch], pix_vals[ch]);
    repeat (2) @(negedge clk);
    #4 check("cap_err_sticky", cap_err, 1);

    // Empty message.
    for (int i = 0; i < NCH; i++) pix_vals[i] = 8'h01;
    run_frame(0, 0, 0, -1, 0);
    for (int ch = 0; ch < NCH; ch++) check("len0_lit", got[ch], (ch < 16) ? 8'h00 : 8'h01);

    // start during PAYLOAD is ignored.
    set_nominal();
    run_frame(2, 0, 1, 24, 0);
    for (int ch = 0; ch < NCH; ch++) check("restart_lit", got[ch], nominal_lit(ch));

    // Reset mid-stream, then a clean frame.
    set_random();
    run_frame(3, 0, 0, -1, 20);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #4 check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    #4 check_all_zero("after_mid_reset");
    set_nominal();
    run_frame(2, 0, 0, -1, 0);
    for (int ch = 0; ch < NCH; ch++) check("post_reset_lit", got[ch], nominal_lit(ch));

    // Random frames.
    for (int r = 0; r < 6; r++) begin
      set_random();
      run_frame($urandom_range(0, 7), 1, 1, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
